// File: rtl/pipe_datapath_fwd.sv
// Three-stage (ID / EX / WB) integer datapath with a 2^ASIZE-entry register file,
// EX/WB-to-EX result forwarding and a write-through register-file read port.
module pipe_datapath_fwd #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  input  logic             stall,
  output logic [DSIZE-1:0] aluout,
  output logic             aluout_valid,
  output logic             ovf,
  output logic             wb_en,
  output logic [ASIZE-1:0] wb_addr
);

  localparam int NREG = 1 << ASIZE;
  localparam int SHW  = $clog2(DSIZE);

  function automatic logic signed [DSIZE-1:0] alu_f(
    input logic [2:0]              op,
    input logic signed [DSIZE-1:0] a,
    input logic signed [DSIZE-1:0] b
  );
    logic signed [DSIZE-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = (a < b) ? DSIZE'(1) : '0;
      3'b110:  r = a << b[SHW-1:0];
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic ovf_f(
    input logic [2:0]              op,
    input logic signed [DSIZE-1:0] a,
    input logic signed [DSIZE-1:0] b,
    input logic signed [DSIZE-1:0] r
  );
    logic o;
    case (op)
      3'b000:  o = (a[DSIZE-1] == b[DSIZE-1]) && (r[DSIZE-1] != a[DSIZE-1]);
      3'b001:  o = (a[DSIZE-1] != b[DSIZE-1]) && (r[DSIZE-1] != a[DSIZE-1]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  logic [DSIZE-1:0] rf_q [NREG];

  logic [5:0]       opcode;
  logic             is_r;
  logic             is_i;
  logic [ASIZE-1:0] rs_a;
  logic [ASIZE-1:0] rt_a;
  logic [ASIZE-1:0] rd_a;
  logic [DSIZE-1:0] rs_val;
  logic [DSIZE-1:0] rt_val;
  logic [DSIZE-1:0] imm_sx;

  logic             vld_p1_q;
  logic [2:0]       op_p1_q;
  logic [DSIZE-1:0] a_p1_q;
  logic [DSIZE-1:0] b_p1_q;
  logic [ASIZE-1:0] rs_p1_q;
  logic [ASIZE-1:0] rt_p1_q;
  logic [ASIZE-1:0] dst_p1_q;
  logic             breg_p1_q;
  logic             we_p1_q;

  logic                    fwd_ok;
  logic signed [DSIZE-1:0] a_ex;
  logic signed [DSIZE-1:0] b_ex;
  logic signed [DSIZE-1:0] res_p2_d;
  logic                    ovf_p2_d;

  logic             vld_p2_q;
  logic             we_p2_q;
  logic             ovf_p2_q;
  logic [ASIZE-1:0] dst_p2_q;
  logic [DSIZE-1:0] res_p2_q;

  // ---- ID: decode and register read ----
  assign opcode = inst[31:26];
  assign is_r   = (opcode == 6'b000000);
  assign is_i   = (opcode[5:3] == 3'b001);
  assign rs_a   = inst[21 +: ASIZE];
  assign rt_a   = inst[16 +: ASIZE];
  assign rd_a   = inst[11 +: ASIZE];
  assign imm_sx = DSIZE'($signed(inst[15:0]));

  // The WB write lands at the end of this cycle, so a same-cycle read takes it directly.
  always_comb begin
    rs_val = rf_q[rs_a];
    rt_val = rf_q[rt_a];
    if (rs_a == '0) begin
      rs_val = '0;
    end else if (wb_en && (wb_addr == rs_a)) begin
      rs_val = res_p2_q;
    end
    if (rt_a == '0) begin
      rt_val = '0;
    end else if (wb_en && (wb_addr == rt_a)) begin
      rt_val = res_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else if (!stall) begin
      vld_p1_q <= inst_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      op_p1_q   <= is_r ? inst[2:0] : opcode[2:0];
      a_p1_q    <= rs_val;
      b_p1_q    <= is_r ? rt_val : imm_sx;
      rs_p1_q   <= rs_a;
      rt_p1_q   <= rt_a;
      breg_p1_q <= is_r;
      we_p1_q   <= is_r | is_i;
      dst_p1_q  <= is_r ? rd_a : rt_a;
    end
  end

  // ---- EX: forward from EX/WB, then ALU ----
  assign fwd_ok = vld_p2_q & we_p2_q & (dst_p2_q != '0);

  always_comb begin
    a_ex = a_p1_q;
    b_ex = b_p1_q;
    if (fwd_ok && (rs_p1_q == dst_p2_q)) begin
      a_ex = res_p2_q;
    end
    if (fwd_ok && breg_p1_q && (rt_p1_q == dst_p2_q)) begin
      b_ex = res_p2_q;
    end
    res_p2_d = alu_f(op_p1_q, a_ex, b_ex);
    ovf_p2_d = vld_p1_q & we_p1_q & ovf_f(op_p1_q, a_ex, b_ex, res_p2_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      we_p2_q  <= 1'b0;
      ovf_p2_q <= 1'b0;
      dst_p2_q <= '0;
      res_p2_q <= '0;
    end else if (!stall) begin
      vld_p2_q <= vld_p1_q;
      we_p2_q  <= vld_p1_q & we_p1_q;
      ovf_p2_q <= ovf_p2_d;
      dst_p2_q <= dst_p1_q;
      res_p2_q <= res_p2_d;
    end
  end

  // ---- WB: outputs and register-file write ----
  assign aluout       = res_p2_q;
  assign aluout_valid = vld_p2_q;
  assign ovf          = ovf_p2_q;
  assign wb_addr      = dst_p2_q;
  assign wb_en        = vld_p2_q & we_p2_q & (dst_p2_q != '0) & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[wb_addr] <= res_p2_q;
    end
  end

endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// Directed bench for pipe_datapath_fwd: per-cycle vector table plus a reset-in-flight sequence.
module tb_pipe_datapath_fwd;

  localparam int DSIZE = 32;
  localparam int ASIZE = 5;
  localparam int NV    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             inst_valid;
  logic [31:0]      inst;
  logic             stall;
  logic [DSIZE-1:0] aluout;
  logic             aluout_valid;
  logic             ovf;
  logic             wb_en;
  logic [ASIZE-1:0] wb_addr;

  pipe_datapath_fwd #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .stall        (stall),
    .aluout       (aluout),
    .aluout_valid (aluout_valid),
    .ovf          (ovf),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr)
  );

  always #5 clk = ~clk;

  // lvl 1 checks aluout_valid and wb_en; lvl 2 also checks aluout, ovf and wb_addr.
  typedef struct {
    logic        iv;
    logic [31:0] in;
    logic        st;
    int          lvl;
    logic [31:0] eo;
    logic        ev;
    logic        eovf;
    logic        ew;
    logic [4:0]  ea;
    string       nm;
  } vec_t;

  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic iv, input logic [31:0] in, input logic st,
                              input int lvl, input logic [31:0] eo, input logic ev,
                              input logic eovf, input logic ew, input logic [4:0] ea,
                              input string nm);
    vec_t v;
    v.iv = iv; v.in = in; v.st = st; v.lvl = lvl; v.eo = eo;
    v.ev = ev; v.eovf = eovf; v.ew = ew; v.ea = ea; v.nm = nm;
    return v;
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [31:0] in, input logic st);
    @(negedge clk);
    rst        = r;
    inst_valid = iv;
    inst       = in;
    stall      = st;
    #1;
  endtask

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_out(input string nm, input int lvl, input logic [31:0] eo,
                           input logic ev, input logic eovf, input logic ew, input logic [4:0] ea);
    if (lvl >= 1) begin
      cmp({nm, ".valid"}, 32'(aluout_valid), 32'(ev));
      cmp({nm, ".wb_en"}, 32'(wb_en), 32'(ew));
    end
    if (lvl >= 2) begin
      cmp({nm, ".aluout"}, 32'(aluout), eo);
      cmp({nm, ".ovf"}, 32'(ovf), 32'(eovf));
      cmp({nm, ".wb_addr"}, 32'(wb_addr), 32'(ea));
    end
  endtask

  initial begin
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = '0;
    stall      = 1'b0;

    // Expected outputs in each row belong to the instruction issued two rows earlier.
    vecs[0]  = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, "reset_state");
    vecs[1]  = mk(1'b1, 32'h2001_0005, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "fill0");
    vecs[2]  = mk(1'b1, 32'h2021_0001, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "fill1");
    vecs[3]  = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd1, "addi_r1_5");
    vecs[4]  = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0006, 1'b1, 1'b0, 1'b1, 5'd1, "fwd_exwb");
    vecs[5]  = mk(1'b1, 32'h2001_0005, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_a");
    vecs[6]  = mk(1'b1, 32'h2002_FFFD, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_b");
    vecs[7]  = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd1, "addi_r1_5b");
    vecs[8]  = mk(1'b1, 32'h0022_1800, 1'b0, 2, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b1, 5'd2, "addi_r2_m3");
    vecs[9]  = mk(1'b0, 32'h0000_0000, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_c");
    vecs[10] = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 5'd3, "add_wt_bypass");
    vecs[11] = mk(1'b1, 32'h2001_0001, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_d");
    vecs[12] = mk(1'b1, 32'h3821_001F, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_e");
    vecs[13] = mk(1'b1, 32'h0001_1001, 1'b0, 2, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 5'd1, "addi_r1_1");
    vecs[14] = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd1, "slli_31");
    vecs[15] = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd2, "sub_ovf");
    vecs[16] = mk(1'b1, 32'h2001_0005, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_f");
    vecs[17] = mk(1'b0, 32'h0000_0000, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_g");
    vecs[18] = mk(1'b1, 32'h2003_0007, 1'b1, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 5'd1, "stall_hold1");
    vecs[19] = mk(1'b1, 32'h2003_0007, 1'b1, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 5'd1, "stall_hold2");
    vecs[20] = mk(1'b1, 32'h2003_0007, 1'b1, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 5'd1, "stall_hold3");
    vecs[21] = mk(1'b1, 32'h0020_2000, 1'b0, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd1, "stall_release");
    vecs[22] = mk(1'b0, 32'h0000_0000, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "no_second_wr");
    vecs[23] = mk(1'b1, 32'h2000_0007, 1'b0, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd4, "add_r4_r1");
    vecs[24] = mk(1'b1, 32'h0000_3000, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_h");
    vecs[25] = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 5'd0, "r0_wr_dropped");
    vecs[26] = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd6, "r0_no_fwd");
    vecs[27] = mk(1'b1, 32'h2007_FFFF, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_i");
    vecs[28] = mk(1'b1, 32'h00E0_4005, 1'b0, 1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, "bubble_j");
    vecs[29] = mk(1'b1, 32'h0800_0000, 1'b0, 2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd7, "addi_r7_m1");
    vecs[30] = mk(1'b0, 32'h0000_0000, 1'b0, 2, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 5'd8, "slt_signed");
    vecs[31] = mk(1'b0, 32'h0000_0000, 1'b0, 1, 32'h0,         1'b1, 1'b0, 1'b0, 5'd0, "noop_opcode");

    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < NV; k++) begin
      drive(1'b0, vecs[k].iv, vecs[k].in, vecs[k].st);
      check_out(vecs[k].nm, vecs[k].lvl, vecs[k].eo, vecs[k].ev, vecs[k].eovf, vecs[k].ew, vecs[k].ea);
    end

    // Reset with ADDI r1,r0,9 in WB and ADDI r5,r0,3 in EX; neither may reach the register file.
    drive(1'b0, 1'b1, 32'h2001_0009, 1'b0);
    drive(1'b0, 1'b1, 32'h2005_0003, 1'b0);
    drive(1'b1, 1'b0, 32'h0000_0000, 1'b0);
    drive(1'b0, 1'b1, 32'h0020_2000, 1'b0);
    check_out("rst_flush", 2, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check_out("rst_no_inflight", 1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check_out("rst_r1_cleared", 2, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_datapath_fwd.md
PIPE_DATAPATH_FWD -- requirements
Module: pipe_datapath_fwd

Interface
REQ-001 SHALL have parameter DSIZE, default 32, datapath width; legal range 16..64.
REQ-002 SHALL have parameter ASIZE, default 5, register-file address width; legal range 2..5; register file holds 2^ASIZE entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inst_valid  input  1  inst carries a real instruction this cycle.
REQ-006 SHALL have port inst  input  32  instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm, [2:0] funct.
REQ-007 SHALL have port stall  input  1  freeze whole pipeline this cycle.
REQ-008 SHALL have port aluout  output  DSIZE  registered ALU result of the instruction in WB.
REQ-009 SHALL have port aluout_valid  output  1  aluout belongs to a valid instruction.
REQ-010 SHALL have port ovf  output  1  signed overflow of the WB instruction (ADD/SUB only, else 0).
REQ-011 SHALL have ports wb_en  output  1 and wb_addr  output  ASIZE  register write performed at the end of this cycle.

Function
REQ-012 SHALL decode: opcode 000000 = R-type, aluop = funct, operand B = rf[rt], dest = rd; opcode 001xxx = I-type, aluop = opcode[2:0], operand B = sign-extended imm to DSIZE, dest = rt; all other opcodes = no-op (no write, aluout_valid still 1).
REQ-013 SHALL use the low ASIZE bits of the rs/rt/rd fields as register addresses.
REQ-014 SHALL implement aluop: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT signed (result 1/0), 110 SLL A by B[log2(DSIZE)-1:0], 111 pass B; results wrap modulo 2^DSIZE.
REQ-015 SHALL set ovf for ADD/SUB when operand signs and result sign indicate two's-complement overflow.
REQ-016 SHALL pipeline in three stages: ID (decode + register read, captured into ID/EX at the end of cycle N), EX (ALU, captured into EX/WB at end of N+1), WB (aluout/aluout_valid/ovf valid during N+2; register write at end of N+2).
REQ-017 SHALL treat register 0 as hardwired zero: reads return 0, writes dropped, never a forwarding source.
REQ-018 SHALL forward the EX/WB result to an EX-stage operand whose source register equals wb_addr with wb_en=1 (back-to-back dependency, zero penalty).
REQ-019 SHALL bypass the register file write-through: an ID read of the address written in the same cycle returns the write data.
REQ-020 SHALL give the EX/WB forward priority over the value latched in ID/EX.
REQ-021 SHALL, with inst_valid=0 and stall=0, insert a bubble (valid=0, no write, no forward source).
REQ-022 SHALL, with stall=1, hold ID/EX, EX/WB and all outputs, ignore inst, and suppress the register write (wb_en=0); the held write occurs exactly once in the first cycle after stall deasserts.
REQ-023 SHALL drive wb_en = EX/WB valid & write-enable & (wb_addr != 0) & ~stall.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, clear all register-file entries to 0, clear all pipeline valid bits, and drive aluout=0, aluout_valid=0, ovf=0, wb_en=0, wb_addr=0 from the next cycle.
REQ-025 SHALL give rst priority over stall and inst_valid; reset mid-operation discards all in-flight instructions with no register write.

Verification
REQ-026 Reset, then ADDI r1,r0,5 (0x20010005) -> aluout=5, aluout_valid=1 two cycles after issue; wb_en=1, wb_addr=1.
REQ-027 Back-to-back 0x20010005 then ADDI r1,r1,1 (0x20210001) -> second aluout=6 (EX/WB forward).
REQ-028 ADDI r1,r0,5; ADDI r2,r0,-3 (0x2002FFFD); bubble; ADD r3,r1,r2 (0x00221800) -> aluout=2; ID write-through bypass.
REQ-029 ADDI r1,r0,1; SLLI r1,r1,31 (0x3821001F); SUB r2,r0,r1 (0x00011001) -> 0x80000000, then 0x80000000 with ovf=1.
REQ-030 Hold stall=1 for 3 cycles while ADDI r1,r0,5 sits in WB -> outputs frozen, wb_en=0; exactly one write after release; a following ADD r4,r1,r0 returns 5.
REQ-031 Assert rst with two instructions in flight -> no writes, all outputs 0 next cycle, subsequent read of r1 returns 0.
